// File: rtl/pp_row_accumulator.sv
// pp_row_accumulator: sequential WIDTH x WIDTH unsigned multiplier.
// Drives one external partial-product row generator (pp_z = pp_x & pp_y)
// and adds one shifted row per clock into a 2*WIDTH-bit accumulator.
// Optional feature macro: PP_ACC_EARLY_TERM_EN. When it is defined, the
// accumulation stops as soon as no multiplier bits remain. When it is not
// defined, every operand pair takes exactly WIDTH accumulation cycles.
// Only WIDTH = 4 is supported, to match the row generator.
module pp_row_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               pp_x,
  output logic [WIDTH-1:0]   pp_y,
  input  logic [WIDTH-1:0]   pp_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W  = $clog2(WIDTH);
  localparam int PROD_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    mplier;
  logic [PROD_W-1:0]   acc;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    mplier_nxt;
  logic                last_row;
  logic                skip_acc;

  // Row returned by the generator, zero-extended and aligned to its weight.
  // The largest possible sum (15*15) fits the accumulator, so no carry-out.
  function automatic logic [PROD_W-1:0] row_term(
    input logic [WIDTH-1:0] row,
    input logic [CNT_W-1:0] sh
  );
    logic [PROD_W-1:0] ext;
    ext      = {{WIDTH{1'b0}}, row};
    row_term = ext << sh;
  endfunction

  // The row generator is fed straight from the operand registers.
  assign pp_y    = mcand;
  assign pp_x    = mplier[0];
  assign product = acc;

  // Decide whether the current accumulation cycle is the final one, and
  // whether an accepted operand pair can skip accumulation altogether.
  always_comb begin
    mplier_nxt = mplier >> 1;
`ifdef PP_ACC_EARLY_TERM_EN
    last_row = (cnt == LAST_CNT) || (mplier_nxt == '0);
    skip_acc = (b == '0);
`else
    last_row = (cnt == LAST_CNT);
    skip_acc = 1'b0;
`endif
  end

  // Control FSM with registered handshake outputs, plus the operand and
  // accumulator registers. All of them clear on reset so that an aborted
  // operation leaves no product and the row generator sees zero inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            mplier   <= b;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (skip_acc) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          acc    <= acc + row_term(pp_z, cnt);
          mplier <= mplier_nxt;
          cnt    <= cnt + 1'b1;
          if (last_row) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
